// File: rtl/mux_arb_n_pkg.sv
// Shared constants and helpers for the N-channel registered selector/arbiter.
// Mode codes and the wrapping channel-index increment live here.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Next channel after idx in an n-channel ring; n need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx >= n - 1)
            return 0;
        else
            return idx + 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
// The request vector is doubled and masked below ptr so one scan covers the wrap.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [SW-1:0] grant_idx,
    output logic          any
);
    import mux_pkg::*;

    logic [2*N-1:0] req2;
    logic [2*N-1:0] mask2;
    logic [2*N-1:0] masked;
    int             win;

    always_comb begin
        req2   = {req, req};
        mask2  = {{N{1'b0}}, {N{1'b1}}} << ptr;
        masked = req2 & mask2;
    end

    always_comb begin
        any = 1'b0;
        win = 0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!any && masked[j]) begin
                any = 1'b1;
                win = (j >= N) ? (j - N) : j;
            end
        end
    end

    always_comb begin
        grant_idx = SW'(win);
        grant_oh  = any ? (N'(1) << win) : '0;
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel, W-bit registered multiplexer with direct-select and round-robin
// modes, delivering the chosen word through a one-entry valid/ready register.
module mux_arb_n #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_l,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);
    import mux_pkg::*;

    logic [SW-1:0] ptr;
    logic [N-1:0]  rr_oh;
    logic [SW-1:0] rr_idx;
    logic          rr_any;

    logic          dir_any;
    logic          grant_any;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  sel_data;
    logic          load;

    logic          vld_p0;
    logic [W-1:0]  data_p0;
    logic [SW-1:0] ch_p0;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr),
        .grant_oh  (rr_oh),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Direct select: codes at or above N match no channel and so never grant.
    always_comb begin
        dir_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i) && in_valid[i])
                dir_any = 1'b1;
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant_any = rr_any;
            grant_idx = rr_idx;
        end else begin
            grant_any = dir_any;
            grant_idx = sel;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i))
                sel_data = in_data[i*W +: W];
        end
    end

    // A slot is free when empty or being drained this cycle; nothing accepts in reset.
    always_comb begin
        load     = rst_n && !en_l && (!vld_p0 || out_ready) && grant_any;
        in_ready = load ? (N'(1) << grant_idx) : '0;
    end

    // Stage p0: output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ch_p0   <= '0;
            ptr     <= '0;
        end else begin
            if (load) begin
                vld_p0  <= 1'b1;
                data_p0 <= sel_data;
                ch_p0   <= grant_idx;
            end else if (out_ready) begin
                vld_p0  <= 1'b0;
            end
            if (load && mode == MODE_RR)
                ptr <= SW'(wrap_inc(32'(grant_idx), N));
        end
    end

    always_comb begin
        out_valid = vld_p0;
        out_data  = data_p0;
        out_ch    = ch_p0;
    end

endmodule
